// File: rtl/bird_physics.sv
// bird_physics: vertical physics engine for the bird sprite.
//   Synchronises and edge-detects the flap button, integrates gravity and
//   velocity once per divided game tick, and clamps to the playfield.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   btn_pressed in   raw asynchronous flap button (level)
//   position    out  [9:0] bird bottom-edge Y, unsigned pixels
//   velocity    out  [5:0] signed px/tick, positive is downward
//   running     out  high in FLY
//   dead        out  high in DEAD
//   flap_pulse  out  one-cycle pulse on the tick that applies a flap
// Configuration:
//   BIRD_PHYSICS_CEIL_KILL_EN  defined: touching Y_TOP in FLY kills the bird;
//                              undefined: the ceiling only clamps.
module bird_physics #(
   parameter int TICK_DIV = 100000,
   parameter int GRAVITY  = 1,
   parameter int FLAP_VEL = 6,
   parameter int MAX_FALL = 8,
   parameter int Y_TOP    = 30,
   parameter int Y_BOTTOM = 479,
   parameter int Y_START  = 240
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              btn_pressed,
   output logic [9:0]        position,
   output logic signed [5:0] velocity,
   output logic              running,
   output logic              dead,
   output logic              flap_pulse
);
   localparam int CW = $clog2(TICK_DIV);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FLY  = 2'd1;
   localparam logic [1:0] S_DEAD = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              meta_q, sync_q, sync_dly_q;
   logic              flap_req_q, flap_req_d;
   logic [9:0]        pos_q, pos_d;
   logic signed [5:0] vel_q, vel_d;
   logic              pulse_q, pulse_d;
   logic              tick, btn_edge, flap_now;
   logic signed [7:0] vel_sum;
   logic signed [5:0] vel_grav, vel_new;
   logic signed [11:0] pos_next;

   assign tick     = cnt_q == CW'(TICK_DIV - 1);
   assign cnt_d    = tick ? '0 : cnt_q + CW'(1);
   assign btn_edge = sync_q & ~sync_dly_q;
   // an edge landing on the tick cycle is applied by that same tick
   assign flap_now = flap_req_q | btn_edge;
   // gravity step, saturated to terminal velocity and to the 6-bit range
   assign vel_sum  = 8'(vel_q) + 8'(GRAVITY);
   assign vel_grav = (vel_sum > 8'(MAX_FALL)) ? 6'(MAX_FALL) :
                     (vel_sum < -8'sd32)      ? -6'sd32 : vel_sum[5:0];
   assign vel_new  = flap_now ? -6'(FLAP_VEL) : vel_grav;
   // widened so overshoot past either playfield edge is detected
   assign pos_next = $signed({2'b00, pos_q}) + 12'(vel_new);

   always_comb begin
      state_d    = state_q;
      pos_d      = pos_q;
      vel_d      = vel_q;
      pulse_d    = 1'b0;
      flap_req_d = flap_req_q;
      case (state_q)
         S_IDLE: begin
            pos_d = 10'(Y_START);
            vel_d = '0;
            if (btn_edge) begin
               state_d    = S_FLY;
               flap_req_d = 1'b1;
            end
         end
         S_FLY: begin
            if (tick) begin
               flap_req_d = 1'b0;
               pulse_d    = flap_now;
               vel_d      = vel_new;
               pos_d      = pos_next[9:0];
               if (pos_next <= 12'(Y_TOP)) begin
                  pos_d = 10'(Y_TOP);
                  vel_d = '0;
`ifdef BIRD_PHYSICS_CEIL_KILL_EN
                  state_d = S_DEAD;
`else
                  state_d = S_FLY;
`endif
               end else if (pos_next >= 12'(Y_BOTTOM)) begin
                  pos_d   = 10'(Y_BOTTOM);
                  vel_d   = '0;
                  state_d = S_DEAD;
               end
            end else begin
               flap_req_d = flap_now;
            end
         end
         S_DEAD: begin
            // the edge that revives the bird must not also launch it
            if (btn_edge) begin
               state_d    = S_IDLE;
               flap_req_d = 1'b0;
               pos_d      = 10'(Y_START);
               vel_d      = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         meta_q     <= 1'b0;
         sync_q     <= 1'b0;
         sync_dly_q <= 1'b0;
         flap_req_q <= 1'b0;
         pos_q      <= 10'(Y_START);
         vel_q      <= '0;
         pulse_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         meta_q     <= btn_pressed;
         sync_q     <= meta_q;
         sync_dly_q <= sync_q;
         flap_req_q <= flap_req_d;
         pos_q      <= pos_d;
         vel_q      <= vel_d;
         pulse_q    <= pulse_d;
      end
   end

   assign position   = pos_q;
   assign velocity   = vel_q;
   assign running    = state_q == S_FLY;
   assign dead       = state_q == S_DEAD;
   assign flap_pulse = pulse_q;
endmodule

// File: tb/tb_bird_physics.sv
// tb_bird_physics: directed bench for bird_physics with a 4-cycle tick.
module tb_bird_physics;
   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              btn_pressed = 1'b0;
   logic [9:0]        position;
   logic signed [5:0] velocity;
   logic              running, dead, flap_pulse;
   int checks = 0;
   int failures = 0;
   int t = 0;

   typedef struct {
      bit press;
      int pos;
      int vel;
      bit run;
      bit dead;
      bit pulse;
   } rec_t;
   rec_t tbl[16];

   bird_physics #(.TICK_DIV(4)) dut (
      .clk(clk), .reset(reset), .btn_pressed(btn_pressed),
      .position(position), .velocity(velocity), .running(running),
      .dead(dead), .flap_pulse(flap_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic to_tick();
      do step(); while (t % 4 != 0);
   endtask

   task automatic press_step();
      btn_pressed = 1'b1;
      step();
      btn_pressed = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      btn_pressed = 1'b0;
      step();
      step();
      reset = 1'b0;
      t = 0;
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
      end
   endtask

   task automatic chk_all(string name, int p, int v, bit r, bit d, bit f);
      chk({name, ".position"}, int'(position), p);
      chk({name, ".velocity"}, int'(velocity), v);
      chk({name, ".running"}, int'(running), int'(r));
      chk({name, ".dead"}, int'(dead), int'(d));
      chk({name, ".flap_pulse"}, int'(flap_pulse), int'(f));
   endtask

   initial begin
      int exp_p;
      tbl[0]  = '{1, 234, -6, 1, 0, 1};
      tbl[1]  = '{0, 229, -5, 1, 0, 0};
      tbl[2]  = '{0, 225, -4, 1, 0, 0};
      tbl[3]  = '{0, 222, -3, 1, 0, 0};
      tbl[4]  = '{0, 220, -2, 1, 0, 0};
      tbl[5]  = '{0, 219, -1, 1, 0, 0};
      tbl[6]  = '{0, 219,  0, 1, 0, 0};
      tbl[7]  = '{0, 220,  1, 1, 0, 0};
      tbl[8]  = '{0, 222,  2, 1, 0, 0};
      tbl[9]  = '{0, 225,  3, 1, 0, 0};
      tbl[10] = '{0, 229,  4, 1, 0, 0};
      tbl[11] = '{0, 234,  5, 1, 0, 0};
      tbl[12] = '{0, 240,  6, 1, 0, 0};
      tbl[13] = '{0, 247,  7, 1, 0, 0};
      tbl[14] = '{0, 255,  8, 1, 0, 0};
      tbl[15] = '{0, 263,  8, 1, 0, 0};

      do_reset();
      chk_all("reset", 240, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         step();
         chk_all($sformatf("idle%0d", i), 240, 0, 0, 0, 0);
      end

      for (int i = 0; i < 16; i++) begin
         if (tbl[i].press) press_step();
         to_tick();
         chk_all($sformatf("fly%0d", i), tbl[i].pos, tbl[i].vel, tbl[i].run, tbl[i].dead, tbl[i].pulse);
         if (tbl[i].pulse) begin
            step();
            chk($sformatf("fly%0d.pulse_end", i), int'(flap_pulse), 0);
         end
      end

      exp_p = 263;
      for (int k = 0; k < 40; k++) begin
         to_tick();
         if (exp_p + 8 >= 479) begin
            chk_all("floor", 479, 0, 0, 1, 0);
            break;
         end
         exp_p += 8;
         chk_all($sformatf("fall%0d", k), exp_p, 8, 1, 0, 0);
      end
      to_tick();
      chk_all("dead_hold0", 479, 0, 0, 1, 0);
      to_tick();
      chk_all("dead_hold1", 479, 0, 0, 1, 0);

      press_step();
      step();
      chk_all("dead_pre_exit", 479, 0, 0, 1, 0);
      step();
      chk_all("dead_exit", 240, 0, 0, 0, 0);
      to_tick();
      chk_all("revived_idle0", 240, 0, 0, 0, 0);
      to_tick();
      chk_all("revived_idle1", 240, 0, 0, 0, 0);

      for (int k = 1; k <= 35; k++) begin
         press_step();
         to_tick();
         if (k < 35) chk_all($sformatf("climb%0d", k), 240 - 6 * k, -6, 1, 0, 1);
      end
`ifdef BIRD_PHYSICS_CEIL_KILL_EN
      chk_all("ceiling_kill", 30, 0, 0, 1, 1);
`else
      chk_all("ceiling_clamp", 30, 0, 1, 0, 1);
      press_step();
      to_tick();
      chk_all("ceiling_again", 30, 0, 1, 0, 1);
      to_tick();
      chk_all("ceiling_release", 31, 1, 1, 0, 0);
`endif

      do_reset();
      press_step();
      to_tick();
      chk_all("coinc_first", 234, -6, 1, 0, 1);
      step();
      press_step();
      to_tick();
      chk_all("coinc_flap", 228, -6, 1, 0, 1);
      step();
      chk("coinc_pulse_end", int'(flap_pulse), 0);
      to_tick();
      chk_all("coinc_after", 223, -5, 1, 0, 0);

      do_reset();
      press_step();
      to_tick();
      chk_all("double_first", 234, -6, 1, 0, 1);
      step();
      step();
      press_step();
      step();
      chk_all("double_mid", 229, -5, 1, 0, 0);
      press_step();
      to_tick();
      chk_all("double_flap", 223, -6, 1, 0, 1);
      to_tick();
      chk_all("double_after", 218, -5, 1, 0, 0);

      do_reset();
      press_step();
      to_tick();
      chk_all("rst_first", 234, -6, 1, 0, 1);
      step();
      press_step();
      step();
      reset = 1'b1;
      step();
      chk_all("rst_mid_flight", 240, 0, 0, 0, 0);
      reset = 1'b0;
      t = 0;
      for (int i = 0; i < 6; i++) step();
      chk_all("rst_settled", 240, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
